// File: rtl/prog_mem_responder.sv
// Program store for the quick CPU core: strobe-driven serial byte loader plus a
// 1-cycle-latency fetch port. Define PGM_CHECKSUM_EN to build the load checksum.
module prog_mem_responder #(
    parameter int unsigned ADDR_W    = 4,
    parameter logic [7:0]  FILL_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              load_strobe,
    input  logic [7:0]        load_data,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [7:0]        fetch_data,
    output logic [ADDR_W:0]   load_count,
    output logic              overflow,
    output logic [7:0]        checksum
);

    localparam int unsigned     DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              edge_q, edge_d;
    logic [7:0]        edge_data_q, edge_data_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              overflow_q, overflow_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [7:0]        fetch_data_q, fetch_data_d;
    logic [7:0]        mem_q [DEPTH];

    logic              accept_s;
    logic              full_s;
    logic              wr_en_s;
    logic              enter_load_s;
    logic              serve_s;
    logic              hit_s;

    // Strobe synchronizer and registered edge; data is latched on the detected edge
    always_comb begin
        sync1_d = load_strobe;
        sync2_d = sync1_q;
        edge_d  = sync1_q & ~sync2_q;
        if (sync1_q && !sync2_q) begin
            edge_data_d = load_data;
        end else begin
            edge_data_d = edge_data_q;
        end
    end

    // Load-side qualifiers: edges only count while LOAD is held with load_en high
    always_comb begin
        full_s       = (load_count_q == FULL_COUNT);
        accept_s     = edge_q && (state_q == ST_LOAD) && load_en;
        wr_en_s      = accept_s && !full_s;
        enter_load_s = (state_q == ST_RUN) && load_en;
    end

    // Mode FSM with load counter and sticky overflow
    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        overflow_d   = overflow_q;
        case (state_q)
            ST_RUN: begin
                if (load_en) begin
                    state_d      = ST_LOAD;
                    load_count_d = '0;
                    overflow_d   = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (!load_en) begin
                    state_d = ST_RUN;
                end else if (accept_s && full_s) begin
                    overflow_d = 1'b1;
                end else if (wr_en_s) begin
                    load_count_d = load_count_q + {{ADDR_W{1'b0}}, 1'b1};
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Fetch port: compare on ADDR_W+1 bits so a full memory makes every address valid
    always_comb begin
        serve_s       = (state_q == ST_RUN) && !load_en && fetch_req;
        hit_s         = ({1'b0, fetch_addr} < load_count_q);
        fetch_valid_d = serve_s;
        if (serve_s && hit_s) begin
            fetch_data_d = mem_q[fetch_addr];
        end else if (serve_s) begin
            fetch_data_d = FILL_BYTE;
        end else begin
            fetch_data_d = fetch_data_q;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            edge_q        <= 1'b0;
            edge_data_q   <= 8'h00;
            load_count_q  <= '0;
            overflow_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= 8'h00;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            edge_q        <= edge_d;
            edge_data_q   <= edge_data_d;
            load_count_q  <= load_count_d;
            overflow_q    <= overflow_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[load_count_q[ADDR_W-1:0]] <= edge_data_q;
        end
    end

`ifdef PGM_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    // Checksum clears on load entry and folds in only bytes actually written
    always_comb begin
        if (enter_load_s) begin
            checksum_d = 8'h00;
        end else if (wr_en_s) begin
            checksum_d = checksum_q ^ edge_data_q;
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= 8'h00;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_s;
    assign unused_s = enter_load_s;
    assign checksum = 8'h00;
`endif

    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign load_count  = load_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_prog_mem_responder.sv
// Scoreboard bench for prog_mem_responder: stimulus pushes expected fetch bytes,
// a negedge monitor pops and compares them against the DUT.
module tb_prog_mem_responder;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_en = 1'b0;
    logic              load_strobe = 1'b0;
    logic [7:0]        load_data = 8'h00;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_valid;
    logic [7:0]        fetch_data;
    logic [ADDR_W:0]   load_count;
    logic              overflow;
    logic [7:0]        checksum;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [7:0] exp_cks_loadA;
    logic [7:0] exp_cks_loadB;
    logic [7:0] exp_cks_loadC;

    prog_mem_responder #(.ADDR_W(ADDR_W), .FILL_BYTE(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_strobe (load_strobe),
        .load_data   (load_data),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .load_count  (load_count),
        .overflow    (overflow),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every valid must match the oldest expectation, in the expected cycle
    always @(negedge clk) begin
        if (fetch_valid) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_valid: got valid=1 data=%02h, none expected (cyc %0d)", fetch_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (fetch_data !== e.data || cyc != e.cyc) begin
                    bad = bad + 1;
                    $display("FAIL fetch: got data=%02h at cyc %0d, want data=%02h at cyc %0d", fetch_data, cyc, e.data, e.cyc);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            total = total + 1;
            bad = bad + 1;
            $display("FAIL missing_valid: got valid=0 at cyc %0d, want data=%02h", cyc, e.data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic strobe_byte(input logic [7:0] b);
        @(posedge clk); #1;
        load_data   = b;
        load_strobe = 1'b1;
        repeat (4) @(posedge clk);
        #1 load_strobe = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic set_load(input logic v);
        @(posedge clk); #1;
        load_en = v;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        exp_t e;
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_addr = a;
        e.data = d;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        fetch_req = 1'b0;
    endtask

    initial begin
        exp_t e;
`ifdef PGM_CHECKSUM_EN
        exp_cks_loadA = 8'h44;
        exp_cks_loadB = 8'h5A;
        exp_cks_loadC = 8'h10;
`else
        exp_cks_loadA = 8'h00;
        exp_cks_loadB = 8'h00;
        exp_cks_loadC = 8'h00;
`endif
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_fetch_data", 32'(fetch_data), 32'h00);
        check("rst_checksum", 32'(checksum), 32'h00);
        rst_n = 1'b1;

        // Nothing loaded: every address returns the fill byte
        issue(4'd0, 8'h00);
        idle();

        // Load 11,22,33,44 and read back-to-back, then beyond the loaded length
        set_load(1'b1);
        strobe_byte(8'h11);
        strobe_byte(8'h22);
        strobe_byte(8'h33);
        strobe_byte(8'h44);
        set_load(1'b0);
        check("loadA_count", 32'(load_count), 32'd4);
        check("loadA_checksum", 32'(checksum), 32'(exp_cks_loadA));
        issue(4'd0, 8'h11);
        issue(4'd1, 8'h22);
        issue(4'd2, 8'h33);
        issue(4'd3, 8'h44);
        issue(4'd7, 8'h00);
        idle();
        repeat (3) @(posedge clk);
        #1 check("hold_data_after_req_drop", 32'(fetch_data), 32'h00);

        // Three-byte reload: old byte at addr 3 must be hidden by the shorter length
        set_load(1'b1);
        check("loadB_cks_cleared", 32'(checksum), 32'h00);
        strobe_byte(8'hA5);
        strobe_byte(8'h0F);
        strobe_byte(8'hF0);
        check("loadB_checksum_in_load", 32'(checksum), 32'(exp_cks_loadB));
        set_load(1'b0);
        check("loadB_count", 32'(load_count), 32'd3);
        issue(4'd2, 8'hF0);
        issue(4'd3, 8'h00);
        idle();

        // Fill past capacity with fetch_req held high throughout the load
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_addr = 4'd15;
        load_en    = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            strobe_byte(8'(i));
        end
        check("ovf_count", 32'(load_count), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_checksum", 32'(checksum), 32'(exp_cks_loadC));
        @(posedge clk); #1;
        load_en = 1'b0;
        @(posedge clk); #1;
        check("no_valid_on_load_exit", 32'(fetch_valid), 32'd0);
        e.data = 8'h10;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        idle();
        issue(4'd0, 8'h01);
        issue(4'd15, 8'h10);
        idle();
        check("ovf_sticky_in_run", 32'(overflow), 32'd1);

        // Re-entering LOAD clears overflow and count; then reset mid-load
        set_load(1'b1);
        check("reload_overflow_clr", 32'(overflow), 32'd0);
        check("reload_count_clr", 32'(load_count), 32'd0);
        strobe_byte(8'hAA);
        strobe_byte(8'hBB);
        check("midload_count", 32'(load_count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(load_count), 32'd0);
        check("async_rst_valid", 32'(fetch_valid), 32'd0);
        check("async_rst_checksum", 32'(checksum), 32'h00);
        load_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(4'd0, 8'h00);
        issue(4'd1, 8'h00);
        idle();

        repeat (5) @(posedge clk);
        #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
